m_10ms_clk: RTL and testbench

- Clock divider that derives a 10 ms period, 50 % duty square wave `clk10ms` from the 50 MHz system clock.
- Feeds the stopwatch time base: downstream counters sample the rising edge of `clk10ms`, or use it as a tick.
- Purely synchronous counter plus toggle register; no handshake.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/m_mod_counter.sv | 26 ++
 rtl/m_10ms_clk.sv | 43 ++++
 tb/tb_m_10ms_clk.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch timing constants and the half-period count helper.
package stopwatch_pkg;

  localparam int unsigned SYS_CLK_HZ   = 50_000_000;
  localparam int unsigned TICK_10MS_US = 10_000;

  // Whole MHz first so the intermediate product stays well inside 32 bits.
  function automatic int unsigned half_cnt(input int unsigned clk_hz,
                                           input int unsigned period_us);
    return clk_hz / 1_000_000 * period_us / 2;
  endfunction

  localparam int unsigned HALF_CNT_10MS = half_cnt(SYS_CLK_HZ, TICK_10MS_US);

endpackage

// File: rtl/m_mod_counter.sv
// Modulo-P_MOD up counter; wrap is high during the cycle cnt sits at P_MOD-1.
module m_mod_counter #(
  parameter int unsigned P_MOD = 2,
  parameter int unsigned P_W   = 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic [P_W-1:0] cnt,
  output logic           wrap
);

  localparam logic [P_W-1:0] LAST = P_W'(P_MOD - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + P_W'(1);
    end
  end

endmodule

// File: rtl/m_10ms_clk.sv
// 50 % duty divided clock for the stopwatch time base; toggles every P_HALF_CNT clk cycles.
module m_10ms_clk
  import stopwatch_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ_HZ   = SYS_CLK_HZ,
  parameter int unsigned P_OUT_PERIOD_US = TICK_10MS_US
) (
  input  logic clk,
  input  logic rst,
  output logic clk10ms
);

  localparam int unsigned P_HALF_CNT = half_cnt(P_CLK_FREQ_HZ, P_OUT_PERIOD_US);
  // Width is clamped so a bad parameter set still elaborates far enough to report the error.
  localparam int unsigned P_CNT_W    = (P_HALF_CNT < 2) ? 1 : $clog2(P_HALF_CNT);

  if (P_HALF_CNT < 2) begin : g_bad_half_cnt
    $error("m_10ms_clk: P_HALF_CNT must be at least 2");
  end

  logic [P_CNT_W-1:0] cnt;
  logic               wrap;

  m_mod_counter #(
    .P_MOD (P_HALF_CNT),
    .P_W   (P_CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Output is a plain register so downstream logic sees a glitch-free level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk10ms <= 1'b0;
    end else if (wrap) begin
      clk10ms <= ~clk10ms;
    end
  end

endmodule

// File: tb/tb_m_10ms_clk.sv
// Self-checking bench: two short-period instances (half counts 25 and 2) driven from one clock.
module tb_m_10ms_clk;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_a;
  logic clk_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Half count 25: 50 cycle period.
  m_10ms_clk #(
    .P_CLK_FREQ_HZ   (50_000_000),
    .P_OUT_PERIOD_US (1)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .clk10ms (clk_a)
  );

  // Half count 2: the smallest legal divider, 4 cycle period.
  m_10ms_clk #(
    .P_CLK_FREQ_HZ   (1_000_000),
    .P_OUT_PERIOD_US (4)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .clk10ms (clk_b)
  );

  typedef struct {
    int   k;
    int   exp_cnt_a;
    logic exp_a;
    int   exp_cnt_b;
    logic exp_b;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Each negedge-to-negedge step contains exactly one rising clk edge.
  task automatic applyStimulus(input int edges);
    repeat (edges) @(negedge clk);
  endtask

  task automatic edgesUntilA(input logic level, output int n);
    n = 0;
    while (clk_a !== level && n < 100) begin
      applyStimulus(1);
      n++;
    end
  endtask

  initial begin
    int k;
    int n;
    int rises_a;
    int rises_b;
    int max_cnt;
    logic prev_a;
    logic prev_b;

    // k: rising clk edges since release -> expected cnt/clk10ms of both instances
    vecs[0]  = '{0,   0,  1'b0, 0, 1'b0};
    vecs[1]  = '{1,   1,  1'b0, 1, 1'b0};
    vecs[2]  = '{2,   2,  1'b0, 0, 1'b1};
    vecs[3]  = '{23,  23, 1'b0, 1, 1'b1};
    vecs[4]  = '{24,  24, 1'b0, 0, 1'b0};
    vecs[5]  = '{25,  0,  1'b1, 1, 1'b0};
    vecs[6]  = '{26,  1,  1'b1, 0, 1'b1};
    vecs[7]  = '{49,  24, 1'b1, 1, 1'b0};
    vecs[8]  = '{50,  0,  1'b0, 0, 1'b1};
    vecs[9]  = '{74,  24, 1'b0, 0, 1'b1};
    vecs[10] = '{75,  0,  1'b1, 1, 1'b1};
    vecs[11] = '{99,  24, 1'b1, 1, 1'b1};
    vecs[12] = '{100, 0,  1'b0, 0, 1'b0};

    #1 rst = 1'b1;

    // Outputs and counters stay cleared for as long as reset is held.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_clk_a", int'(clk_a), 0);
      checkOutput("reset_cnt_a", int'(dut_a.cnt), 0);
      checkOutput("reset_clk_b", int'(clk_b), 0);
    end

    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].k - k);
      k = vecs[i].k;
      checkOutput($sformatf("vec%0d_cnt_a", k), int'(dut_a.cnt), vecs[i].exp_cnt_a);
      checkOutput($sformatf("vec%0d_clk_a", k), int'(clk_a), int'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_cnt_b", k), int'(dut_b.cnt), vecs[i].exp_cnt_b);
      checkOutput($sformatf("vec%0d_clk_b", k), int'(clk_b), int'(vecs[i].exp_b));
    end

    // At k=100 clk_a has just fallen: measure one low and one high phase.
    edgesUntilA(1'b1, n);
    checkOutput("low_phase_edges", n, 25);
    edgesUntilA(1'b0, n);
    checkOutput("high_phase_edges", n, 25);

    // Five full periods from k=150: edges 151..400.
    rises_a = 0;
    rises_b = 0;
    max_cnt = 0;
    prev_a  = clk_a;
    prev_b  = clk_b;
    for (int i = 0; i < 250; i++) begin
      applyStimulus(1);
      if (clk_a && !prev_a) rises_a++;
      if (clk_b && !prev_b) rises_b++;
      if (int'(dut_a.cnt) > max_cnt) max_cnt = int'(dut_a.cnt);
      prev_a = clk_a;
      prev_b = clk_b;
    end
    checkOutput("five_period_rises_a", rises_a, 5);
    checkOutput("window_rises_b", rises_b, 62);
    checkOutput("max_cnt_a", max_cnt, 24);

    // k=400 -> 435: clk_a high with cnt 10, then reset between clk edges.
    applyStimulus(35);
    checkOutput("pre_reset_clk_a", int'(clk_a), 1);
    checkOutput("pre_reset_cnt_a", int'(dut_a.cnt), 10);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_clk_a", int'(clk_a), 0);
    checkOutput("async_reset_cnt_a", int'(dut_a.cnt), 0);
    checkOutput("async_reset_clk_b", int'(clk_b), 0);
    @(negedge clk);
    rst = 1'b0;
    edgesUntilA(1'b1, n);
    checkOutput("restart_first_rise", n, 25);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
